// File: rtl/udp_reg_pkg.sv
// Shared register-ring definitions: bus widths, ring payload and unmapped-read constant.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package udp_reg_pkg;

  localparam int unsigned REG_ADDR_W = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned REG_DATA_W = `CPCI_NF2_DATA_WIDTH;
  localparam int unsigned SW_REG_W   = 32;
  localparam int unsigned CNT_W      = 32;

  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  // Ring fields that travel together through a responder stage.
  typedef struct packed {
    logic                  req;
    logic                  ack;
    logic                  rd_wr_l;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } reg_ring_t;

  // Width of the block-select tag given the number of local index bits.
  function automatic int unsigned tag_width(input int unsigned block_addr_w);
    return REG_ADDR_W - block_addr_w;
  endfunction

endpackage

// File: rtl/udp_reg_counter_bank.sv
// Bank of 32-bit wrapping event counters with a combinational read mux.
// Optional clear-on-read when UDP_REG_RESP_CLR_ON_RD_EN is defined.
module udp_reg_counter_bank
  import udp_reg_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS = 2,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_COUNTERS-1:0] inc_i,
  input  logic                    rd_clr_i,
  input  logic [IDX_W-1:0]        rd_sel_i,
  output logic [CNT_W-1:0]        rd_data_c_o
);

  logic [CNT_W-1:0] cnt_d [NUM_COUNTERS];
  logic [CNT_W-1:0] cnt_q [NUM_COUNTERS];

  always_comb begin
    rd_data_c_o = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (32'(rd_sel_i) == i) rd_data_c_o = cnt_q[i];
    end
  end

  // A coincident clear and increment leaves the counter at 1.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(inc_i[i]);
`ifdef UDP_REG_RESP_CLR_ON_RD_EN
      if (rd_clr_i && (32'(rd_sel_i) == i)) cnt_d[i] = CNT_W'(inc_i[i]);
`endif
    end
  end

`ifndef UDP_REG_RESP_CLR_ON_RD_EN
  logic unused_rd_clr;
  assign unused_rd_clr = rd_clr_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/udp_reg_responder.sv
// Register-ring responder: hardware counters plus software registers on a 1-cycle ring stage.
// Define UDP_REG_RESP_CLR_ON_RD_EN to make counter reads clear the counter.
module udp_reg_responder
  import udp_reg_pkg::*;
#(
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned BLOCK_ADDR_WIDTH  = 2,
  parameter logic [`UDP_REG_ADDR_WIDTH-BLOCK_ADDR_WIDTH-1:0] BLOCK_TAG = 21'h000100,
  parameter int unsigned NUM_COUNTERS      = 2,
  parameter int unsigned NUM_SW_REGS       = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
  input  logic [NUM_COUNTERS-1:0]         counter_inc,
  output logic [NUM_SW_REGS*32-1:0]       sw_regs
);

  localparam int unsigned IDX_W = BLOCK_ADDR_WIDTH;
  localparam int unsigned TAG_W = tag_width(BLOCK_ADDR_WIDTH);

  logic [IDX_W-1:0]    idx_c;
  logic [TAG_W-1:0]    tag_c;
  logic                local_c;
  logic                is_cnt_c;
  logic                is_sw_c;
  logic                cnt_clr_c;
  logic [CNT_W-1:0]    cnt_rd_c;
  logic [SW_REG_W-1:0] sw_rd_c;

  reg_ring_t                    ring_d, ring_q;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q;
  logic [SW_REG_W-1:0]          sw_d [NUM_SW_REGS];
  logic [SW_REG_W-1:0]          sw_q [NUM_SW_REGS];

  assign idx_c     = reg_addr_in[IDX_W-1:0];
  assign tag_c     = reg_addr_in[REG_ADDR_W-1:IDX_W];
  assign local_c   = reg_req_in && !reg_ack_in && (tag_c == BLOCK_TAG);
  assign is_cnt_c  = 32'(idx_c) < NUM_COUNTERS;
  assign is_sw_c   = !is_cnt_c && (32'(idx_c) < (NUM_COUNTERS + NUM_SW_REGS));
  assign cnt_clr_c = local_c && reg_rd_wr_L_in && is_cnt_c;

  udp_reg_counter_bank #(
    .NUM_COUNTERS (NUM_COUNTERS),
    .IDX_W        (IDX_W)
  ) u_counter_bank (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (counter_inc),
    .rd_clr_i    (cnt_clr_c),
    .rd_sel_i    (idx_c),
    .rd_data_c_o (cnt_rd_c)
  );

  // Software register read mux and write decode.
  always_comb begin
    sw_rd_c = '0;
    sw_d    = sw_q;
    for (int unsigned i = 0; i < NUM_SW_REGS; i++) begin
      if (32'(idx_c) == (NUM_COUNTERS + i)) begin
        sw_rd_c = sw_q[i];
        if (local_c && !reg_rd_wr_L_in) sw_d[i] = SW_REG_W'(reg_data_in);
      end
    end
  end

  // Ring stage: pass through, or acknowledge and substitute read data.
  always_comb begin
    ring_d.req     = reg_req_in;
    ring_d.ack     = reg_ack_in || local_c;
    ring_d.rd_wr_l = reg_rd_wr_L_in;
    ring_d.addr    = reg_addr_in;
    ring_d.data    = reg_data_in;
    if (local_c && reg_rd_wr_L_in) begin
      if (is_cnt_c)     ring_d.data = REG_DATA_W'(cnt_rd_c);
      else if (is_sw_c) ring_d.data = REG_DATA_W'(sw_rd_c);
      else              ring_d.data = REG_DATA_W'(UNMAPPED_DATA);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q <= '0;
      src_q  <= '0;
      for (int unsigned i = 0; i < NUM_SW_REGS; i++) sw_q[i] <= '0;
    end else begin
      ring_q <= ring_d;
      src_q  <= reg_src_in;
      sw_q   <= sw_d;
    end
  end

  assign reg_req_out     = ring_q.req;
  assign reg_ack_out     = ring_q.ack;
  assign reg_rd_wr_L_out = ring_q.rd_wr_l;
  assign reg_addr_out    = ring_q.addr;
  assign reg_data_out    = ring_q.data;
  assign reg_src_out     = src_q;

  for (genvar g = 0; g < NUM_SW_REGS; g++) begin : g_sw_flat
    assign sw_regs[g*32 +: 32] = sw_q[g];
  end

endmodule

// File: tb/tb_udp_reg_responder.sv
// Directed self-checking bench for udp_reg_responder (one software register, index 3 unmapped).
module tb_udp_reg_responder;

  localparam int unsigned NSW = 1;
  localparam int unsigned NC  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_in, ack_in, rdwr_in;
  logic [22:0]   addr_in;
  logic [31:0]   data_in;
  logic [1:0]    src_in;
  logic          req_out, ack_out, rdwr_out;
  logic [22:0]   addr_out;
  logic [31:0]   data_out;
  logic [1:0]    src_out;
  logic [NC-1:0] counter_inc;
  logic [NSW*32-1:0] sw_regs;

  int n_cmp = 0;
  int n_bad = 0;

  logic [59:0] ring_out;
  assign ring_out = {req_out, ack_out, rdwr_out, addr_out, data_out, src_out};

  always #5 clk = ~clk;

  udp_reg_responder #(
    .UDP_REG_SRC_WIDTH (2),
    .BLOCK_ADDR_WIDTH  (2),
    .BLOCK_TAG         (21'h000100),
    .NUM_COUNTERS      (NC),
    .NUM_SW_REGS       (NSW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_req_in      (req_in),
    .reg_ack_in      (ack_in),
    .reg_rd_wr_L_in  (rdwr_in),
    .reg_addr_in     (addr_in),
    .reg_data_in     (data_in),
    .reg_src_in      (src_in),
    .reg_req_out     (req_out),
    .reg_ack_out     (ack_out),
    .reg_rd_wr_L_out (rdwr_out),
    .reg_addr_out    (addr_out),
    .reg_data_out    (data_out),
    .reg_src_out     (src_out),
    .counter_inc     (counter_inc),
    .sw_regs         (sw_regs)
  );

  task automatic drive(input logic req, input logic ack, input logic rd,
                       input logic [22:0] addr, input logic [31:0] data, input logic [1:0] src);
    req_in = req; ack_in = ack; rdwr_in = rd; addr_in = addr; data_in = data; src_in = src;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    counter_inc = '0;
    drive(1'b1, 1'b0, 1'b0, 23'h000402, 32'h5555_AAAA, 2'b11);
    step();
    step();
    n_cmp++;
    if (ring_out !== 60'h0) begin
      n_bad++; $display("FAIL reset_ring: got %h expected 0", ring_out);
    end
    n_cmp++;
    if (sw_regs !== 32'h0) begin
      n_bad++; $display("FAIL reset_sw: got %h expected 0", sw_regs);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 2'b00);
    step();
  endtask

  task automatic test_passthrough();
    drive(1'b1, 1'b0, 1'b1, 23'h000000, 32'h1234_5678, 2'b10);
    step();
    n_cmp++;
    if (ring_out !== {1'b1, 1'b0, 1'b1, 23'h000000, 32'h1234_5678, 2'b10}) begin
      n_bad++; $display("FAIL passthrough_nonlocal: got %h", ring_out);
    end
    // req low with a matching address must not be claimed
    drive(1'b0, 1'b0, 1'b1, 23'h000402, 32'h0F0F_0F0F, 2'b01);
    step();
    n_cmp++;
    if (ring_out !== {1'b0, 1'b0, 1'b1, 23'h000402, 32'h0F0F_0F0F, 2'b01}) begin
      n_bad++; $display("FAIL passthrough_noreq: got %h", ring_out);
    end
  endtask

  task automatic test_sw_write_read();
    drive(1'b1, 1'b0, 1'b0, 23'h000402, 32'hCAFE_0001, 2'b01);
    step();
    n_cmp++;
    if (ring_out !== {1'b1, 1'b1, 1'b0, 23'h000402, 32'hCAFE_0001, 2'b01}) begin
      n_bad++; $display("FAIL sw_write_ack: got %h", ring_out);
    end
    n_cmp++;
    if (sw_regs !== 32'hCAFE_0001) begin
      n_bad++; $display("FAIL sw_write_reg: got %h expected cafe0001", sw_regs);
    end
    drive(1'b1, 1'b0, 1'b1, 23'h000402, 32'h0000_0000, 2'b10);
    step();
    n_cmp++;
    if (ring_out !== {1'b1, 1'b1, 1'b1, 23'h000402, 32'hCAFE_0001, 2'b10}) begin
      n_bad++; $display("FAIL sw_read: got %h", ring_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 23'h000402, 32'h0BAD_F00D, 2'b00);
    step();
    drive(1'b1, 1'b0, 1'b1, 23'h000402, 32'hFFFF_FFFF, 2'b00);
    n_cmp++;
    if (sw_regs !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL b2b_write: got %h expected 0badf00d", sw_regs);
    end
    step();
    n_cmp++;
    if (data_out !== 32'h0BAD_F00D || ack_out !== 1'b1) begin
      n_bad++; $display("FAIL b2b_read: got data %h ack %b expected 0badf00d ack 1", data_out, ack_out);
    end
  endtask

  task automatic test_ack_in();
    drive(1'b1, 1'b1, 1'b0, 23'h000402, 32'h1111_2222, 2'b01);
    step();
    n_cmp++;
    if (ring_out !== {1'b1, 1'b1, 1'b0, 23'h000402, 32'h1111_2222, 2'b01}) begin
      n_bad++; $display("FAIL ackin_pass: got %h", ring_out);
    end
    n_cmp++;
    if (sw_regs !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL ackin_noupdate: got %h expected 0badf00d", sw_regs);
    end
    drive(1'b1, 1'b0, 1'b0, 23'h000802, 32'h3333_4444, 2'b11);
    step();
    n_cmp++;
    if (ring_out !== {1'b1, 1'b0, 1'b0, 23'h000802, 32'h3333_4444, 2'b11}) begin
      n_bad++; $display("FAIL othertag_pass: got %h", ring_out);
    end
    n_cmp++;
    if (sw_regs !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL othertag_noupdate: got %h expected 0badf00d", sw_regs);
    end
  endtask

  task automatic test_counter();
    logic [31:0] exp_c0_again, exp_c1_again;
`ifdef UDP_REG_RESP_CLR_ON_RD_EN
    exp_c0_again = 32'd0;
    exp_c1_again = 32'd1;
`else
    exp_c0_again = 32'd5;
    exp_c1_again = 32'd2;
`endif
    drive(1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 2'b00);
    counter_inc = 2'b01;
    for (int i = 0; i < 5; i++) step();
    counter_inc = 2'b00;
    drive(1'b1, 1'b0, 1'b1, 23'h000400, 32'h0, 2'b00);
    step();
    n_cmp++;
    if (data_out !== 32'd5 || ack_out !== 1'b1) begin
      n_bad++; $display("FAIL cnt0_read: got data %h ack %b expected 5 ack 1", data_out, ack_out);
    end
    step();
    n_cmp++;
    if (data_out !== exp_c0_again) begin
      n_bad++; $display("FAIL cnt0_reread: got %h expected %h", data_out, exp_c0_again);
    end
    drive(1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 2'b00);
    counter_inc = 2'b10;
    step();
    drive(1'b1, 1'b0, 1'b1, 23'h000401, 32'h0, 2'b00);
    step();
    counter_inc = 2'b00;
    n_cmp++;
    if (data_out !== 32'd1) begin
      n_bad++; $display("FAIL cnt1_read_inc: got %h expected 1", data_out);
    end
    step();
    n_cmp++;
    if (data_out !== exp_c1_again) begin
      n_bad++; $display("FAIL cnt1_reread: got %h expected %h", data_out, exp_c1_again);
    end
    // writes to a counter are acknowledged but ignored
    drive(1'b1, 1'b0, 1'b0, 23'h000400, 32'h1234_5678, 2'b00);
    step();
    n_cmp++;
    if (data_out !== 32'h1234_5678 || ack_out !== 1'b1) begin
      n_bad++; $display("FAIL cnt_write_ack: got data %h ack %b", data_out, ack_out);
    end
    drive(1'b1, 1'b0, 1'b1, 23'h000400, 32'h0, 2'b00);
    step();
    n_cmp++;
    if (data_out !== exp_c0_again) begin
      n_bad++; $display("FAIL cnt_write_noeffect: got %h expected %h", data_out, exp_c0_again);
    end
  endtask

  task automatic test_unmapped();
    drive(1'b1, 1'b0, 1'b1, 23'h000403, 32'h0, 2'b01);
    step();
    n_cmp++;
    if (ring_out !== {1'b1, 1'b1, 1'b1, 23'h000403, 32'hDEAD_BEEF, 2'b01}) begin
      n_bad++; $display("FAIL unmapped_read: got %h", ring_out);
    end
    drive(1'b1, 1'b0, 1'b0, 23'h000403, 32'h7777_8888, 2'b01);
    step();
    n_cmp++;
    if (ack_out !== 1'b1 || data_out !== 32'h7777_8888 || sw_regs !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL unmapped_write: got ack %b data %h sw %h", ack_out, data_out, sw_regs);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 23'h000402, 32'hAAAA_5555, 2'b10);
    reset = 1'b1;
    step();
    n_cmp++;
    if (ring_out !== 60'h0) begin
      n_bad++; $display("FAIL rstmid_ring: got %h expected 0", ring_out);
    end
    n_cmp++;
    if (sw_regs !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_sw: got %h expected 0", sw_regs);
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 23'h000403, 32'h0, 2'b00);
    step();
    n_cmp++;
    if (data_out !== 32'hDEAD_BEEF || ack_out !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_unmapped: got data %h ack %b", data_out, ack_out);
    end
    drive(1'b1, 1'b0, 1'b1, 23'h000400, 32'h0, 2'b00);
    step();
    n_cmp++;
    if (data_out !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_cnt: got %h expected 0", data_out);
    end
    drive(1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 2'b00);
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sw_write_read();
    test_back_to_back();
    test_ack_in();
    test_counter();
    test_unmapped();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
